// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU execute stage.
package alu_pkg;

   localparam int unsigned W  = 8;
   localparam int unsigned PW = 5;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      ADC = 3'd1,
      SUB = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      SHL = 3'd5,
      SHR = 3'd6,
      MUL = 3'd7
   } op_t;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } state_t;

endpackage

// File: rtl/alu_ex_if.sv
// Issue/writeback bundle between the register file and the execute stage.
interface alu_ex_if;
   import alu_pkg::*;

   logic          valid_in;
   op_t           op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [PW-1:0] ptr_w_in;
   logic          wr_en_in;
   logic          stall;
   logic          wb_we;
   logic [PW-1:0] wb_ptr;
   logic [W-1:0]  wb_data;
   logic          r_overflow;

   // Upstream side: issues instructions, consumes writeback and flag.
   modport master (
      output valid_in, op, a, b, ptr_w_in, wr_en_in,
      input  stall, wb_we, wb_ptr, wb_data, r_overflow
   );

   // Execute stage side.
   modport slave (
      input  valid_in, op, a, b, ptr_w_in, wr_en_in,
      output stall, wb_we, wb_ptr, wb_data, r_overflow
   );

endinterface

// File: rtl/alu_ex_mul_seq.sv
// Shift-add multiplier: one partial product per clock, fixed iteration count.
module mul_seq #(
   parameter int unsigned W         = 8,
   parameter int unsigned MUL_ITERS = W
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] prod
);

   localparam int unsigned CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

   logic [2*W-1:0] r_mcand;
   logic [2*W-1:0] r_acc;
   logic [W-1:0]   r_mplier;
   logic [CW-1:0]  r_cnt;
   logic           r_busy;
   logic [2*W-1:0] w_acc_next;

   // prod is the accumulator including the current iteration, so the
   // consumer can load it on the same edge that done is seen.
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign done       = r_busy && (r_cnt == CW'(MUL_ITERS - 1));
   assign prod       = w_acc_next;

   // Load operands on start, then iterate until the last count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_busy   <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (start) begin
         r_busy   <= 1'b1;
         r_mcand  <= {{W{1'b0}}, a};
         r_mplier <= b;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (done) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_ex.sv
// Execute stage: single-cycle ALU, sequential multiply, writeback and flag.
module alu_ex
   import alu_pkg::*;
#(
   parameter int unsigned W         = alu_pkg::W,
   parameter int unsigned PW        = alu_pkg::PW,
   parameter int unsigned MUL_ITERS = W
) (
   input  logic     clk,
   input  logic     reset_n,
   alu_ex_if.slave  bus
);

   state_t          r_state;
   logic            r_wb_we;
   logic [PW-1:0]   r_wb_ptr;
   logic [W-1:0]    r_wb_data;
   logic            r_ovf;
   logic [PW-1:0]   r_mul_ptr;
   logic            r_mul_we;

   logic [W-1:0]    w_res;
   logic            w_ovf;
   logic            w_accept;
   logic            w_mul_start;
   logic            w_mul_done;
   logic [2*W-1:0]  w_prod;

   assign w_accept    = (r_state == IDLE) && bus.valid_in;
   assign w_mul_start = w_accept && (bus.op == MUL);

   assign bus.stall      = (r_state == MUL_RUN);
   assign bus.wb_we      = r_wb_we;
   assign bus.wb_ptr     = r_wb_ptr;
   assign bus.wb_data    = r_wb_data;
   assign bus.r_overflow = r_ovf;

   mul_seq #(
      .W         (W),
      .MUL_ITERS (MUL_ITERS)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (w_mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .done    (w_mul_done),
      .prod    (w_prod)
   );

   // Single-cycle result and flag; ops that leave the flag alone keep r_ovf.
   always_comb begin
      w_res = '0;
      w_ovf = r_ovf;
      case (bus.op)
         ADD:     {w_ovf, w_res} = {1'b0, bus.a} + {1'b0, bus.b};
         ADC:     {w_ovf, w_res} = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, r_ovf};
         SUB: begin
            w_res = bus.a - bus.b;
            w_ovf = (bus.a < bus.b);
         end
         AND:     w_res = bus.a & bus.b;
         XOR:     w_res = bus.a ^ bus.b;
         SHL: begin
            w_res = {bus.a[W-2:0], 1'b0};
            w_ovf = bus.a[W-1];
         end
         SHR: begin
            w_res = {1'b0, bus.a[W-1:1]};
            w_ovf = bus.a[0];
         end
         default: w_res = '0;
      endcase
   end

   // Control FSM with registered writeback; MUL destination is captured at
   // accept because upstream may present the next instruction while stalled.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_wb_we   <= 1'b0;
         r_wb_ptr  <= '0;
         r_wb_data <= '0;
         r_ovf     <= 1'b0;
         r_mul_ptr <= '0;
         r_mul_we  <= 1'b0;
      end else begin
         r_wb_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_mul_start) begin
                  r_state   <= MUL_RUN;
                  r_mul_ptr <= bus.ptr_w_in;
                  r_mul_we  <= bus.wr_en_in;
               end else if (w_accept) begin
                  r_wb_we <= bus.wr_en_in;
                  r_ovf   <= w_ovf;
                  if (bus.wr_en_in) begin
                     r_wb_ptr  <= bus.ptr_w_in;
                     r_wb_data <= w_res;
                  end
               end
            end
            MUL_RUN: begin
               if (w_mul_done) begin
                  r_state <= IDLE;
                  r_wb_we <= r_mul_we;
                  r_ovf   <= |w_prod[2*W-1:W];
                  if (r_mul_we) begin
                     r_wb_ptr  <= r_mul_ptr;
                     r_wb_data <= w_prod[W-1:0];
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_ex.md
Name: alu_ex

Overview:
- Execute stage directly downstream of the register file.
- Consumes the two read operands (do_a, do_b) and the destination pointer. Computes an 8-bit result and returns it to the register file write port as di/we/ptr_w.
- Owns the architectural overflow/carry flag that drives the register file's r_overflow input.
- Single-cycle ops complete in one clock. MUL is an 8-iteration shift-add sequence that stalls the front end.

Parameters:
- W, 8, datapath width (only 8 is verified)
- PW, 5, register pointer width
- MUL_ITERS, 8, multiply iterations; must equal W

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- valid_in  in  1  instruction present this cycle
- op  in  3  operation code (alu_pkg::op_t)
- a  in  W  operand A (rf do_a)
- b  in  W  operand B (rf do_b)
- ptr_w_in  in  PW  destination register
- wr_en_in  in  1  1 = write result back; 0 = flags only
- stall  out  1  1 = busy; upstream holds all inputs stable
- wb_we  out  1  write-enable to rf (rf we)
- wb_ptr  out  PW  write pointer to rf (rf ptr_w)
- wb_data  out  W  write data to rf (rf di)
- r_overflow  out  1  flag register, to rf r_overflow

Behaviour:
- Reset (reset_n=0 at an edge):
  - State goes to IDLE.
  - stall=0, wb_we=0, wb_ptr=0, wb_data=0, r_overflow=0.
  - Any in-flight MUL is aborted and produces no writeback.
- Accept rule: an instruction is accepted at an edge when valid_in=1 and state=IDLE. In MUL_RUN, inputs are ignored.
- stall is a combinational decode of state: stall = (state==MUL_RUN).
- Opcodes (3-bit):
  - ADD=0: {ovf,res} = a+b
  - ADC=1: {ovf,res} = a+b+r_overflow
  - SUB=2: res = a-b; ovf = (a<b)
  - AND=3: ovf unchanged
  - XOR=4: ovf unchanged
  - SHL=5: res = a<<1; ovf = a[7]
  - SHR=6: res = a>>1, logical; ovf = a[0]
  - MUL=7: res = low byte of a*b; ovf = (high byte != 0)
- Single-cycle ops (accepted at edge T):
  - During cycle T+1: wb_we=wr_en_in, wb_ptr=ptr_w_in, wb_data=res, and r_overflow is updated.
  - Latency 1; throughput 1 per cycle.
- MUL (accepted at edge T):
  - Captures mcand={8'h00,a}, mplier=b, acc=16'h0, cnt=0. State goes to MUL_RUN; stall=1 during T+1..T+8.
  - Each MUL_RUN edge:
    - if mplier[0], acc += mcand
    - mcand <<= 1
    - mplier >>= 1
    - cnt++
  - On the edge where cnt==7, state returns to IDLE and wb_data, wb_ptr, wb_we and r_overflow load from the final acc. The writeback pulse appears in cycle T+9.
  - The next instruction can be accepted at the edge ending cycle T+9 (IDLE).
- wb_we is a one-cycle pulse per accepted instruction with wr_en_in=1.
  - Cycles with no accept, or with wr_en_in=0: wb_we=0.
  - wb_data and wb_ptr hold their last value when wb_we=0.
- Flag rules:
  - r_overflow changes only on completion of an accepted op and is unaffected by wr_en_in.
  - ADC reads the flag value present before the op.
  - Back-to-back ADD then ADC chains the carry correctly with no bubble.
- Illegal/boundary cases:
  - valid_in during MUL_RUN has no effect.
  - b=0 in MUL gives res=0, ovf=0 after the full 8 iterations; there is no early exit.
  - Shifts ignore b.
- Reset mid-MUL: the next cycle is IDLE with stall=0 and no wb_we pulse.

Decomposition:
- alu_pkg holds:
  - op_t enum (ADD..MUL, 3-bit)
  - state_t enum {IDLE, MUL_RUN}
  - localparams W, PW
- One sub-module, mul_seq. It holds the shift-add datapath:
  - inputs: clk, reset_n, start, a, b
  - outputs: done (one-cycle pulse), prod[15:0]
- alu_ex owns the FSM, the single-cycle ALU, writeback registers and the flag.

Test Plan:
- Reset, then ADD a=F0 b=20 wr_en=1 ptr=3 -> in cycle T+1: wb_we=1, wb_ptr=3, wb_data=10, r_overflow=1. Next cycle ADC a=01 b=01 -> wb_data=03, r_overflow=0.
- SUB a=05 b=07 -> wb_data=FE, r_overflow=1. Then AND a=FF b=0F -> wb_data=0F, r_overflow stays 1.
- MUL a=0D b=0B ptr=2 accepted at T -> stall=1 during T+1..T+8 with no wb_we. In T+9: wb_we=1, wb_data=8F, r_overflow=0, stall=0.
- MUL a=10 b=10 -> wb_data=00, r_overflow=1 at T+9. A different instruction held on the inputs during the stall executes exactly once, with its writeback in T+10.
- SHL a=81 wr_en=0 -> wb_we=0, r_overflow=1. Then SHR a=02 -> wb_data=01, r_overflow=0.
- MUL a=FF b=FF, reset_n=0 at T+4 -> from T+5: stall=0, wb_we=0, r_overflow=0. No writeback ever appears for the aborted MUL.
